// File: rtl/stb_meas_seq.sv
// Measurement sequencer between the CSR bank and stb_gen: runs N lock/strobe/settle/sample
// iterations and accumulates comparator hits for a sweep point.
module stb_meas_seq #(
   parameter int CNT_W   = 16,
   parameter int TMO_W   = 24,
   parameter int TIMEOUT = 2**20
) (
   input  logic             clk_i,
   input  logic             arstn_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [CNT_W-1:0] n_samples_i,
   input  logic [7:0]       settle_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [CNT_W-1:0] hit_cnt_o,
   output logic [CNT_W-1:0] sample_cnt_o,
   input  logic             gen_rdy_i,
   input  logic             gen_err_i,
   output logic             stb_req_o,
   input  logic             stb_valid_i,
   input  logic             cmp_i
);

   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_WAIT_RDY   = 4'd1;
   localparam logic [3:0] S_REQ        = 4'd2;
   localparam logic [3:0] S_WAIT_CLR   = 4'd3;
   localparam logic [3:0] S_WAIT_VALID = 4'd4;
   localparam logic [3:0] S_SETTLE     = 4'd5;
   localparam logic [3:0] S_SAMPLE     = 4'd6;
   localparam logic [3:0] S_DONE       = 4'd7;
   localparam logic [3:0] S_ERR        = 4'd8;

   localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);

   logic [3:0]       state_q, state_d;
   logic             busy_q, busy_d, done_q, done_d, err_q, err_d, req_q, req_d;
   logic [CNT_W-1:0] hit_q, hit_d, smp_q, smp_d, n_q, n_d;
   logic [7:0]       settle_q, settle_d, set_cnt_q, set_cnt_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             cmp_s1_q, cmp_s2_q;

   logic [TMO_W-1:0] tmo_inc;
   logic [CNT_W-1:0] smp_inc;
   logic             waiting, active, tmo_hit;

   assign tmo_inc = tmo_q + TMO_W'(1);
   assign smp_inc = smp_q + CNT_W'(1);
   assign waiting = (state_q == S_WAIT_RDY) || (state_q == S_WAIT_CLR) || (state_q == S_WAIT_VALID);
   assign active  = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
   assign tmo_hit = waiting && (tmo_inc == TMO_LIM);

   always_comb begin
      state_d   = state_q;
      done_d    = 1'b0;
      err_d     = err_q;
      hit_d     = hit_q;
      smp_d     = smp_q;
      n_d       = n_q;
      settle_d  = settle_q;
      set_cnt_d = set_cnt_q;
      if (abort_i) begin
         state_d = S_IDLE;
      end else if (gen_err_i && active) begin
         state_d = S_ERR;
      end else if (tmo_hit) begin
         state_d = S_ERR;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  n_d      = n_samples_i;
                  settle_d = settle_i;
                  hit_d    = '0;
                  smp_d    = '0;
                  err_d    = 1'b0;
                  state_d  = (n_samples_i == '0) ? S_DONE : S_WAIT_RDY;
               end
            end
            S_WAIT_RDY:   if (gen_rdy_i) state_d = S_REQ;
            S_REQ:        state_d = S_WAIT_CLR;
            // Wait for the previous strobe's valid to drop so only a fresh strobe is sampled
            S_WAIT_CLR:   if (!stb_valid_i) state_d = S_WAIT_VALID;
            S_WAIT_VALID: begin
               if (stb_valid_i) begin
                  state_d   = S_SETTLE;
                  set_cnt_d = settle_q;
               end
            end
            S_SETTLE: begin
               if (set_cnt_q == 8'd0) state_d = S_SAMPLE;
               else                   set_cnt_d = set_cnt_q - 8'd1;
            end
            S_SAMPLE: begin
               smp_d   = smp_inc;
               hit_d   = hit_q + {{(CNT_W-1){1'b0}}, cmp_s2_q};
               state_d = (smp_inc == n_q) ? S_DONE : S_REQ;
            end
            S_DONE: begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
            S_ERR: begin
               done_d  = 1'b1;
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
      tmo_d  = ((state_d != state_q) || !waiting) ? '0 : tmo_inc;
      busy_d = (state_d != S_IDLE);
      req_d  = (state_d == S_REQ);
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         req_q     <= 1'b0;
         hit_q     <= '0;
         smp_q     <= '0;
         n_q       <= '0;
         settle_q  <= '0;
         set_cnt_q <= '0;
         tmo_q     <= '0;
         cmp_s1_q  <= 1'b0;
         cmp_s2_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         req_q     <= req_d;
         hit_q     <= hit_d;
         smp_q     <= smp_d;
         n_q       <= n_d;
         settle_q  <= settle_d;
         set_cnt_q <= set_cnt_d;
         tmo_q     <= tmo_d;
         cmp_s1_q  <= cmp_i;
         cmp_s2_q  <= cmp_s1_q;
      end
   end

   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign stb_req_o    = req_q;
   assign hit_cnt_o    = hit_q;
   assign sample_cnt_o = smp_q;

endmodule

// File: tb/tb_stb_meas_seq.sv
// Directed bench for stb_meas_seq with a small stb_gen responder (valid 5 cycles after each request).
module tb_stb_meas_seq;

   logic        clk_i = 1'b0;
   logic        arstn_i = 1'b0;
   logic        start_i = 1'b0;
   logic        abort_i = 1'b0;
   logic [15:0] n_samples_i = '0;
   logic [7:0]  settle_i = '0;
   logic        gen_rdy_i = 1'b1;
   logic        gen_err_i = 1'b0;
   logic        stb_valid_i = 1'b0;
   logic        cmp_i = 1'b0;
   logic        busy_o, done_o, err_o, stb_req_o;
   logic [15:0] hit_cnt_o, sample_cnt_o;

   int total = 0;
   int bad = 0;
   int req_cnt = 0;
   int done_cnt = 0;
   bit auto_valid = 1'b0;
   int resp_idx = 0;
   int base_idx = 0;
   logic [7:0] cmp_pat = '0;
   logic [2:0] pidx;

   stb_meas_seq #(.CNT_W(16), .TMO_W(24), .TIMEOUT(100)) dut (
      .clk_i(clk_i), .arstn_i(arstn_i), .start_i(start_i), .abort_i(abort_i),
      .n_samples_i(n_samples_i), .settle_i(settle_i), .busy_o(busy_o), .done_o(done_o),
      .err_o(err_o), .hit_cnt_o(hit_cnt_o), .sample_cnt_o(sample_cnt_o),
      .gen_rdy_i(gen_rdy_i), .gen_err_i(gen_err_i), .stb_req_o(stb_req_o),
      .stb_valid_i(stb_valid_i), .cmp_i(cmp_i)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (stb_req_o) req_cnt <= req_cnt + 1;
      if (done_o)    done_cnt <= done_cnt + 1;
   end

   // stb_gen stand-in: drop valid on a request, present cmp for that sample, raise valid 5 cycles later
   always begin
      @(negedge clk_i);
      if (auto_valid && stb_req_o) begin
         stb_valid_i = 1'b0;
         pidx = 3'(resp_idx - base_idx);
         cmp_i = cmp_pat[pidx];
         resp_idx++;
         repeat (5) @(negedge clk_i);
         stb_valid_i = 1'b1;
      end
   end

   task automatic go(input logic [15:0] n, input logic [7:0] s);
      n_samples_i = n;
      settle_i = s;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int lim, output int cyc, output bit got);
      cyc = 0;
      got = 1'b0;
      while (cyc < lim && !got) begin
         @(negedge clk_i);
         cyc++;
         if (done_o) got = 1'b1;
      end
   endtask

   task automatic wait_samples(input int want, input int lim, output bit got);
      got = 1'b0;
      for (int i = 0; i < lim && !got; i++) begin
         @(negedge clk_i);
         if (sample_cnt_o == 16'(want)) got = 1'b1;
      end
   endtask

   task automatic test_reset();
      #12;
      total++; if ({busy_o, done_o, err_o, stb_req_o} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {busy_o, done_o, err_o, stb_req_o}); end
      total++; if (hit_cnt_o !== 16'd0) begin bad++; $display("FAIL reset_hit: got %0d want 0", hit_cnt_o); end
      total++; if (sample_cnt_o !== 16'd0) begin bad++; $display("FAIL reset_sample: got %0d want 0", sample_cnt_o); end
      @(negedge clk_i);
      arstn_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_basic();
      int cyc, r0;
      bit got;
      auto_valid = 1'b1;
      base_idx = resp_idx;
      cmp_pat = 8'b1010_1010;
      r0 = req_cnt;
      go(16'd4, 8'd3);
      total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy_o); end
      wait_done(200, cyc, got);
      total++; if (!got || cyc != 46) begin bad++; $display("FAIL basic_latency: got %0d (seen %0d) want 46", cyc, got); end
      total++; if (hit_cnt_o !== 16'd2) begin bad++; $display("FAIL basic_hit: got %0d want 2", hit_cnt_o); end
      total++; if (sample_cnt_o !== 16'd4) begin bad++; $display("FAIL basic_sample: got %0d want 4", sample_cnt_o); end
      total++; if ({busy_o, err_o} !== 2'b00) begin bad++; $display("FAIL basic_busy_err: got %b want 00", {busy_o, err_o}); end
      @(negedge clk_i);
      total++; if (done_o !== 1'b0) begin bad++; $display("FAIL basic_done_width: got %b want 0", done_o); end
      total++; if (req_cnt - r0 != 4) begin bad++; $display("FAIL basic_req_count: got %0d want 4", req_cnt - r0); end
   endtask

   task automatic test_zero();
      int r0;
      r0 = req_cnt;
      go(16'd0, 8'd0);
      total++; if ({busy_o, done_o} !== 2'b10) begin bad++; $display("FAIL zero_first: got %b want 10", {busy_o, done_o}); end
      total++; if (sample_cnt_o !== 16'd0 || hit_cnt_o !== 16'd0) begin bad++; $display("FAIL zero_clear: got %0d/%0d want 0/0", sample_cnt_o, hit_cnt_o); end
      @(negedge clk_i);
      total++; if ({busy_o, done_o} !== 2'b01) begin bad++; $display("FAIL zero_done: got %b want 01", {busy_o, done_o}); end
      @(negedge clk_i);
      total++; if (done_o !== 1'b0) begin bad++; $display("FAIL zero_done_width: got %b want 0", done_o); end
      total++; if (req_cnt != r0) begin bad++; $display("FAIL zero_no_req: got %0d want 0", req_cnt - r0); end
   endtask

   task automatic test_timeout();
      int cyc, r0;
      bit got;
      gen_rdy_i = 1'b0;
      r0 = req_cnt;
      go(16'd1, 8'd0);
      wait_done(300, cyc, got);
      total++; if (!got || cyc != 101) begin bad++; $display("FAIL tmo_latency: got %0d (seen %0d) want 101", cyc, got); end
      total++; if ({err_o, busy_o} !== 2'b10) begin bad++; $display("FAIL tmo_err: got %b want 10", {err_o, busy_o}); end
      @(negedge clk_i);
      total++; if ({err_o, done_o} !== 2'b10) begin bad++; $display("FAIL tmo_sticky: got %b want 10", {err_o, done_o}); end
      total++; if (req_cnt != r0) begin bad++; $display("FAIL tmo_no_req: got %0d want 0", req_cnt - r0); end
      gen_rdy_i = 1'b1;
   endtask

   task automatic test_stale_valid();
      int cyc;
      bit got;
      auto_valid = 1'b0;
      stb_valid_i = 1'b1;
      cmp_i = 1'b1;
      go(16'd1, 8'd2);
      repeat (4) @(negedge clk_i);
      stb_valid_i = 1'b0;
      repeat (6) @(negedge clk_i);
      total++; if ({busy_o, sample_cnt_o} !== {1'b1, 16'd0}) begin bad++; $display("FAIL stale_no_sample: got busy=%b n=%0d want busy=1 n=0", busy_o, sample_cnt_o); end
      stb_valid_i = 1'b1;
      wait_done(50, cyc, got);
      total++; if (!got || cyc != 6) begin bad++; $display("FAIL stale_latency: got %0d (seen %0d) want 6", cyc, got); end
      total++; if (sample_cnt_o !== 16'd1 || hit_cnt_o !== 16'd1) begin bad++; $display("FAIL stale_counts: got %0d/%0d want 1/1", sample_cnt_o, hit_cnt_o); end
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL stale_err_cleared: got %b want 0", err_o); end
      @(negedge clk_i);
   endtask

   task automatic test_abort();
      int cyc, d0;
      bit got;
      auto_valid = 1'b1;
      base_idx = resp_idx;
      cmp_pat = 8'hFF;
      go(16'd8, 8'd3);
      d0 = done_cnt;
      wait_samples(2, 200, got);
      total++; if (!got) begin bad++; $display("FAIL abort_reach: got %0d samples want 2", sample_cnt_o); end
      repeat (7) @(negedge clk_i);
      abort_i = 1'b1;
      @(negedge clk_i);
      abort_i = 1'b0;
      total++; if ({busy_o, done_o, stb_req_o} !== 3'b000) begin bad++; $display("FAIL abort_idle: got %b want 000", {busy_o, done_o, stb_req_o}); end
      total++; if (sample_cnt_o !== 16'd2 || hit_cnt_o !== 16'd2) begin bad++; $display("FAIL abort_counts: got %0d/%0d want 2/2", sample_cnt_o, hit_cnt_o); end
      repeat (20) @(negedge clk_i);
      total++; if (done_cnt != d0 || busy_o !== 1'b0 || sample_cnt_o !== 16'd2) begin bad++; $display("FAIL abort_quiet: got done=%0d busy=%b n=%0d want 0/0/2", done_cnt - d0, busy_o, sample_cnt_o); end
      base_idx = resp_idx;
      go(16'd1, 8'd3);
      total++; if (sample_cnt_o !== 16'd0 || hit_cnt_o !== 16'd0) begin bad++; $display("FAIL abort_restart_clear: got %0d/%0d want 0/0", sample_cnt_o, hit_cnt_o); end
      wait_done(100, cyc, got);
      total++; if (!got || sample_cnt_o !== 16'd1) begin bad++; $display("FAIL abort_restart_run: got seen=%0d n=%0d want 1/1", got, sample_cnt_o); end
      @(negedge clk_i);
   endtask

   task automatic test_gen_err();
      int cyc;
      bit got;
      auto_valid = 1'b1;
      base_idx = resp_idx;
      cmp_pat = 8'h00;
      go(16'd4, 8'd3);
      wait_samples(1, 100, got);
      total++; if (!got) begin bad++; $display("FAIL generr_reach: got %0d samples want 1", sample_cnt_o); end
      n_samples_i = 16'd0;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      total++; if ({busy_o, sample_cnt_o} !== {1'b1, 16'd1}) begin bad++; $display("FAIL busy_start_ignored: got busy=%b n=%0d want 1/1", busy_o, sample_cnt_o); end
      @(negedge clk_i);
      gen_err_i = 1'b1;
      @(negedge clk_i);
      gen_err_i = 1'b0;
      wait_done(20, cyc, got);
      total++; if (!got || cyc != 1) begin bad++; $display("FAIL generr_latency: got %0d (seen %0d) want 1", cyc, got); end
      total++; if ({err_o, busy_o, sample_cnt_o} !== {2'b10, 16'd1}) begin bad++; $display("FAIL generr_state: got err=%b busy=%b n=%0d want 1/0/1", err_o, busy_o, sample_cnt_o); end
      repeat (5) @(negedge clk_i);
      total++; if (err_o !== 1'b1) begin bad++; $display("FAIL generr_sticky: got %b want 1", err_o); end
      go(16'd0, 8'd0);
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL generr_clear: got %b want 0", err_o); end
      repeat (2) @(negedge clk_i);
   endtask

   task automatic test_reset_midrun();
      bit got;
      auto_valid = 1'b1;
      go(16'd4, 8'd3);
      wait_samples(1, 100, got);
      total++; if (!got) begin bad++; $display("FAIL midrst_reach: got %0d samples want 1", sample_cnt_o); end
      arstn_i = 1'b0;
      #1;
      total++; if ({busy_o, stb_req_o, err_o, done_o} !== 4'b0000) begin bad++; $display("FAIL midrst_flags: got %b want 0000", {busy_o, stb_req_o, err_o, done_o}); end
      total++; if (sample_cnt_o !== 16'd0 || hit_cnt_o !== 16'd0) begin bad++; $display("FAIL midrst_counts: got %0d/%0d want 0/0", sample_cnt_o, hit_cnt_o); end
      @(negedge clk_i);
      arstn_i = 1'b1;
      @(negedge clk_i);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_timeout();
      test_stale_valid();
      test_abort();
      test_gen_err();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
